// File: rtl/ram_ff_pkg.sv
// Shared constants, port-index type and priority helper for the multi-port flip-flop RAM.
package ram_ff_pkg;

  localparam int DW_MAX   = 8192;
  localparam int AW_MAX   = 12;
  localparam int PORT_MAX = 8;

  typedef logic [$clog2(PORT_MAX)-1:0] port_idx_t;

  // One-hot of the lowest set bit; isolates the winning port of a request mask.
  function automatic logic [PORT_MAX-1:0] prio_onehot(input logic [PORT_MAX-1:0] req);
    return req & (~req + PORT_MAX'(1));
  endfunction

endpackage

// File: rtl/ram_ff_wr_arb.sv
// Write arbiter: resolves same-address writes by fixed priority (lowest port index wins)
// and flags a collision whenever any enabled ports share an address.
module ram_ff_wr_arb
  import ram_ff_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int NUM_WR    = 2
) (
  input  logic [NUM_WR-1:0]           wr_req,
  input  logic [NUM_WR*ADDRWIDTH-1:0] addr_w,
  output logic [NUM_WR-1:0]           commit,
  output logic                        collision
);

  always_comb begin
    logic [PORT_MAX-1:0] match;
    logic [PORT_MAX-1:0] win;
    // NOTE: every combinational output and temporary gets a value before any
    // conditional use, so no path through the block leaves state implied (no latch).
    commit    = '0;
    collision = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      match = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        match[j] = wr_req[i] && wr_req[j] &&
                   (addr_w[i*ADDRWIDTH +: ADDRWIDTH] == addr_w[j*ADDRWIDTH +: ADDRWIDTH]);
      end
      win       = prio_onehot(match);
      commit[i] = win[i];
      if ((match & ~win) != '0) collision = 1'b1;
    end
  end

endmodule

// File: rtl/ram_ff_mp.sv
// Multi-port flip-flop RAM with prioritised write collisions and optional registered read.
// Optional macro RAM_FF_BYPASS_EN: write-first forwarding into the registered read path.
module ram_ff_mp
  import ram_ff_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3,
  parameter int NUM_WR    = 2,
  parameter int NUM_RD    = 2,
  parameter int RD_REG    = 1,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_WR-1:0]           en_w_n,
  input  logic [NUM_WR*ADDRWIDTH-1:0] addr_w,
  input  logic [NUM_WR*DATAWIDTH-1:0] data_w,
  input  logic [NUM_RD-1:0]           en_r_n,
  input  logic [NUM_RD*ADDRWIDTH-1:0] addr_r,
  output logic [NUM_RD*DATAWIDTH-1:0] data_r,
  output logic [NUM_RD-1:0]           rd_valid,
  output logic                        wr_collision,
  output logic [CNT_W-1:0]            collision_cnt
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  if (DATAWIDTH < 1 || DATAWIDTH > DW_MAX || ADDRWIDTH < 1 || ADDRWIDTH > AW_MAX ||
      NUM_WR < 1 || NUM_WR > PORT_MAX || NUM_RD < 1 || NUM_RD > PORT_MAX ||
      RD_REG < 0 || RD_REG > 1 || CNT_W < 1 || CNT_W > 32) begin : g_param_err
    $error("ram_ff_mp: parameter out of legal range");
    $fatal(1, "ram_ff_mp: elaboration aborted");
  end

  logic [DATAWIDTH-1:0]        mem [DEPTH];
  logic [NUM_WR-1:0]           wr_req;
  logic [NUM_RD-1:0]           rd_req;
  logic [NUM_WR-1:0]           commit;
  logic                        collision;
  logic [NUM_RD*DATAWIDTH-1:0] rd_next;

  // Ports whose address is unknown are dropped for the cycle in simulation.
  always_comb begin
    wr_req = ~en_w_n;
    rd_req = ~en_r_n;
`ifndef SYNTHESIS
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_req[i] && $isunknown(addr_w[i*ADDRWIDTH +: ADDRWIDTH])) begin
        wr_req[i] = 1'b0;
        $warning("ram_ff_mp: X/Z on write address of port %0d", i);
      end
    end
    for (int j = 0; j < NUM_RD; j++) begin
      if (rd_req[j] && $isunknown(addr_r[j*ADDRWIDTH +: ADDRWIDTH])) begin
        rd_req[j] = 1'b0;
        $warning("ram_ff_mp: X/Z on read address of port %0d", j);
      end
    end
`endif
  end

`ifndef SYNTHESIS
  always @(clk) begin
    if ($isunknown(clk)) $warning("ram_ff_mp: X/Z on clk");
  end
`endif

  ram_ff_wr_arb #(
    .ADDRWIDTH (ADDRWIDTH),
    .NUM_WR    (NUM_WR)
  ) u_wr_arb (
    .wr_req    (wr_req),
    .addr_w    (addr_w),
    .commit    (commit),
    .collision (collision)
  );

  // Committed ports always target distinct words, so write order inside the loop is irrelevant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this store is flops, not a RAM macro, so clearing every word on reset is
      // both legal and required; a real SRAM array would not be reset this way.
      for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (commit[i]) mem[addr_w[i*ADDRWIDTH +: ADDRWIDTH]] <= data_w[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) begin
      wr_collision  <= 1'b0;
      collision_cnt <= '0;
    end else begin
      wr_collision <= collision;
      if (collision && collision_cnt != {CNT_W{1'b1}}) collision_cnt <= collision_cnt + 1'b1;
    end
  end

  always_comb begin
    rd_next = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_next[j*DATAWIDTH +: DATAWIDTH] = mem[addr_r[j*ADDRWIDTH +: ADDRWIDTH]];
`ifdef RAM_FF_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++) begin
        if (RD_REG != 0 && commit[i] &&
            addr_w[i*ADDRWIDTH +: ADDRWIDTH] == addr_r[j*ADDRWIDTH +: ADDRWIDTH])
          rd_next[j*DATAWIDTH +: DATAWIDTH] = data_w[i*DATAWIDTH +: DATAWIDTH];
      end
`endif
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_r   <= '0;
        rd_valid <= '0;
      end else begin
        rd_valid <= rd_req;
        for (int j = 0; j < NUM_RD; j++) begin
          if (rd_req[j]) data_r[j*DATAWIDTH +: DATAWIDTH] <= rd_next[j*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end else begin : g_rd_comb
    always_comb begin
      data_r   = '0;
      rd_valid = rd_req;
      for (int j = 0; j < NUM_RD; j++) begin
        if (rd_req[j]) data_r[j*DATAWIDTH +: DATAWIDTH] = rd_next[j*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ram_ff_mp.sv
// Bench for ram_ff_mp: directed checks on a registered-read instance and randomised traffic
// on a combinational-read 4W/3R instance, both against array-based reference models.
module tb_ram_ff_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (2W/2R, registered read)
  logic [1:0]  a_en_w_n = 2'b11;
  logic [5:0]  a_addr_w = '0;
  logic [15:0] a_data_w = '0;
  logic [1:0]  a_en_r_n = 2'b11;
  logic [5:0]  a_addr_r = '0;
  logic [15:0] a_data_r;
  logic [1:0]  a_rd_valid;
  logic        a_coll;
  logic [7:0]  a_cnt;

  // Instance B: 4W/3R, combinational read
  logic [3:0]  b_en_w_n = 4'hF;
  logic [11:0] b_addr_w = '0;
  logic [31:0] b_data_w = '0;
  logic [2:0]  b_en_r_n = 3'h7;
  logic [8:0]  b_addr_r = '0;
  logic [23:0] b_data_r;
  logic [2:0]  b_rd_valid;
  logic        b_coll;
  logic [7:0]  b_cnt;

  ram_ff_mp u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .en_w_n (a_en_w_n), .addr_w (a_addr_w), .data_w (a_data_w),
    .en_r_n (a_en_r_n), .addr_r (a_addr_r), .data_r (a_data_r),
    .rd_valid (a_rd_valid), .wr_collision (a_coll), .collision_cnt (a_cnt)
  );

  ram_ff_mp #(.NUM_WR(4), .NUM_RD(3), .RD_REG(0)) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .en_w_n (b_en_w_n), .addr_w (b_addr_w), .data_w (b_data_w),
    .en_r_n (b_en_r_n), .addr_r (b_addr_r), .data_r (b_data_r),
    .rd_valid (b_rd_valid), .wr_collision (b_coll), .collision_cnt (b_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];
  int cnt_a = 0;
  int cnt_b = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  task automatic a_wr(input int p, input bit en, input logic [2:0] addr, input logic [7:0] data);
    a_en_w_n[p]        = ~en;
    a_addr_w[p*3 +: 3] = addr;
    a_data_w[p*8 +: 8] = data;
  endtask

  task automatic a_rd(input int p, input bit en, input logic [2:0] addr);
    a_en_r_n[p]        = ~en;
    a_addr_r[p*3 +: 3] = addr;
  endtask

  task automatic a_idle();
    a_en_w_n = 2'b11;
    a_en_r_n = 2'b11;
  endtask

  logic [2:0] a0, a1;
  logic [7:0] d0, d1, old;
  bit         exp_coll;
  bit         bwe [4];
  logic [2:0] bwa [4];
  logic [7:0] bwd [4];
  bit         bre [3];
  logic [2:0] bra [3];

  initial begin
    for (int k = 0; k < 8; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end

    // Reset state
    tick();
    rst_n = 1'b1;
    check("rst_a_data", a_data_r, 0);
    check("rst_a_vld", a_rd_valid, 0);
    check("rst_a_coll", a_coll, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_b_cnt", b_cnt, 0);
    check("rst_b_vld", b_rd_valid, 0);

    // Read every address after reset
    for (int k = 0; k < 8; k++) begin
      a_rd(0, 1, 3'(k));
      a_rd(1, 1, 3'(7 - k));
      tick();
      check("t1_data", a_data_r, 0);
      check("t1_vld", a_rd_valid, 2'b11);
    end
    a_idle();
    tick();
    check("t1_vld_off", a_rd_valid, 0);
    check("t1_cnt", a_cnt, 0);

    // Two distinct-address writes in one cycle
    a_wr(0, 1, 3'd2, 8'hA5);
    a_wr(1, 1, 3'd5, 8'h3C);
    tick();
    mem_a[2] = 8'hA5;
    mem_a[5] = 8'h3C;
    check("t2_coll", a_coll, 0);
    a_idle();
    a_rd(0, 1, 3'd2);
    a_rd(1, 1, 3'd5);
    tick();
    check("t2_rd", a_data_r, {8'h3C, 8'hA5});
    check("t2_coll2", a_coll, 0);
    a_idle();

    // Same-address collision: port 0 wins
    a_wr(0, 1, 3'd3, 8'h11);
    a_wr(1, 1, 3'd3, 8'h22);
    tick();
    mem_a[3] = 8'h11;
    cnt_a = sat_inc(cnt_a);
    check("t3_coll", a_coll, 1);
    check("t3_cnt", a_cnt, cnt_a);
    a_idle();
    a_rd(0, 1, 3'd3);
    tick();
    check("t3_pulse", a_coll, 0);
    check("t3_rd", a_data_r[7:0], 8'h11);
    a_idle();

    // Random two-port writes, model: lower index overrides
    for (int r = 0; r < 12; r++) begin
      a0 = 3'($urandom_range(0, 7));
      a1 = (r % 3 == 0) ? a0 : 3'($urandom_range(0, 7));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      a_wr(0, 1, a0, d0);
      a_wr(1, 1, a1, d1);
      tick();
      exp_coll = (a0 == a1);
      mem_a[a1] = d1;
      mem_a[a0] = d0;
      if (exp_coll) cnt_a = sat_inc(cnt_a);
      check("rw_coll", a_coll, exp_coll);
      check("rw_cnt", a_cnt, cnt_a);
    end
    a_idle();
    tick();
    check("rw_coll_off", a_coll, 0);
    for (int k = 0; k < 4; k++) begin
      a_rd(0, 1, 3'(2 * k));
      a_rd(1, 1, 3'(2 * k + 1));
      tick();
      check("rw_rd", a_data_r, {mem_a[2 * k + 1], mem_a[2 * k]});
    end
    a_idle();

    // Counter saturation over 300 consecutive collision cycles
    a_wr(0, 1, 3'd3, 8'h11);
    a_wr(1, 1, 3'd3, 8'h22);
    for (int r = 0; r < 300; r++) begin
      tick();
      cnt_a = sat_inc(cnt_a);
    end
    mem_a[3] = 8'h11;
    check("sat_cnt", a_cnt, cnt_a);
    check("sat_coll", a_coll, 1);
    a_idle();
    tick();
    check("sat_hold", a_cnt, 255);
    check("sat_coll_off", a_coll, 0);

    // Read and write the same address at one edge
    a_wr(0, 1, 3'd4, 8'h00);
    tick();
    mem_a[4] = 8'h00;
    old = mem_a[4];
    a_wr(0, 1, 3'd4, 8'h77);
    a_rd(0, 1, 3'd4);
    tick();
`ifdef RAM_FF_BYPASS_EN
    check("rw_same_edge", a_data_r[7:0], 8'h77);
`else
    check("rw_same_edge", a_data_r[7:0], old);
`endif
    mem_a[4] = 8'h77;
    a_idle();
    a_rd(0, 1, 3'd4);
    tick();
    check("rw_after", a_data_r[7:0], 8'h77);
    a_idle();

    // Reset overrides a colliding write and reads in the same cycle
    a_wr(0, 1, 3'd1, 8'hFF);
    a_wr(1, 1, 3'd1, 8'hEE);
    a_rd(0, 1, 3'd4);
    a_rd(1, 1, 3'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_idle();
    for (int k = 0; k < 8; k++) mem_a[k] = '0;
    cnt_a = 0;
    check("r5_data", a_data_r, 0);
    check("r5_vld", a_rd_valid, 0);
    check("r5_coll", a_coll, 0);
    check("r5_cnt", a_cnt, 0);
    a_rd(0, 1, 3'd1);
    a_rd(1, 1, 3'd4);
    tick();
    check("r5_mem", a_data_r, 0);
    check("r5_vld2", a_rd_valid, 2'b11);
    a_idle();

    // Random traffic on the combinational-read instance
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        bwe[i] = ($urandom_range(0, 2) != 0);
        bwa[i] = 3'($urandom_range(0, 7));
        bwd[i] = 8'($urandom);
        b_en_w_n[i]         = ~bwe[i];
        b_addr_w[i*3 +: 3]  = bwa[i];
        b_data_w[i*8 +: 8]  = bwd[i];
      end
      for (int j = 0; j < 3; j++) begin
        bre[j] = ($urandom_range(0, 3) != 0);
        bra[j] = 3'($urandom_range(0, 7));
        b_en_r_n[j]        = ~bre[j];
        b_addr_r[j*3 +: 3] = bra[j];
      end
      #1;
      for (int j = 0; j < 3; j++) begin
        check("b_data", b_data_r[j*8 +: 8], bre[j] ? mem_b[bra[j]] : 8'h00);
        check("b_vld", b_rd_valid[j], bre[j]);
      end
      exp_coll = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int k = i + 1; k < 4; k++)
          if (bwe[i] && bwe[k] && bwa[i] == bwa[k]) exp_coll = 1'b1;
      for (int i = 3; i >= 0; i--)
        if (bwe[i]) mem_b[bwa[i]] = bwd[i];
      if (exp_coll) cnt_b = sat_inc(cnt_b);
      tick();
      check("b_coll", b_coll, exp_coll);
      check("b_cnt", b_cnt, cnt_b);
    end
    b_en_w_n = 4'hF;
    b_en_r_n = 3'h7;
    #1;
    check("b_off_data", b_data_r, 0);
    check("b_off_vld", b_rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_ff_mp.md
Name: ram_ff_mp

Overview:
Parametrised multi-port flip-flop RAM: NUM_WR write ports and NUM_RD read ports, all with active-low enables.
- Fixed-priority resolution of same-address write collisions, with a pulse and a saturating collision counter.
- Read path selectable between combinational and one-cycle registered, with a read-valid output.
- Register-file/scratch-store primitive for datapath blocks needing more than two ports.

Parameters:
DATAWIDTH, 8, word width in bits (legal 1..8192)
ADDRWIDTH, 3, address width; depth = 2**ADDRWIDTH (legal 1..12)
NUM_WR, 2, number of write ports (legal 1..8)
NUM_RD, 2, number of read ports (legal 1..8)
RD_REG, 1, 0 = combinational read, 1 = registered read (latency 1)
CNT_W, 8, width of collision counter (legal 1..32)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
en_w_n  input  NUM_WR  per-port write enable, active-low
addr_w  input  NUM_WR*ADDRWIDTH  packed write addresses, port i at [i*ADDRWIDTH +: ADDRWIDTH]
data_w  input  NUM_WR*DATAWIDTH  packed write data, same packing
en_r_n  input  NUM_RD  per-port read enable, active-low
addr_r  input  NUM_RD*ADDRWIDTH  packed read addresses
data_r  output  NUM_RD*DATAWIDTH  packed read data
rd_valid  output  NUM_RD  read data valid per port
wr_collision  output  1  one-cycle pulse: a same-address write collision occurred at the previous edge
collision_cnt  output  CNT_W  saturating count of collision cycles

Behaviour:
- Reset: one clock, synchronous active-low, rst_n sampled at rising edge of clk.
  - At that edge: all mem words, data_r, rd_valid, wr_collision and collision_cnt go to 0.
  - Reset overrides any write or read in the same cycle.
- Writes:
  - Each port i with en_w_n[i]=0 writes data_w[i] to addr_w[i] at the rising edge.
  - Ports with distinct addresses all commit in the same cycle.
  - Same-address collision: the lowest-index enabled port wins; the others are dropped.
- Collision reporting:
  - If two or more enabled ports share an address (any address), wr_collision=1 for exactly the next cycle.
  - collision_cnt increments by 1 per collision cycle (not per pair) and saturates at 2**CNT_W-1.
- Read, RD_REG=0:
  - data_r[j] = en_r_n[j] ? 0 : mem[addr_r[j]], combinational.
  - rd_valid[j] = ~en_r_n[j].
  - A write is visible on the cycle after its edge.
- Read, RD_REG=1:
  - When en_r_n[j]=0 at an edge, data_r[j] loads mem[addr_r[j]] (pre-write contents; read-old) and rd_valid[j]=1 next cycle.
  - When disabled, data_r[j] holds its last value and rd_valid[j]=0.
- Reads never affect mem. Any number of read ports may target the same address.
- Elaboration checks for out-of-range parameters: $error plus $fatal. Simulation-only $warning on X/Z on clk, or on an address of an enabled port; that port is treated as disabled for that cycle.

Optional Feature:
Macro RAM_FF_BYPASS_EN.
- Defined, with RD_REG=1: a read whose address matches a write committing at the same edge loads the winning write data (write-first).
- Defined, with RD_REG=0: no effect.
- Undefined: read-old as above; no bypass muxes are synthesised.

Decomposition:
- Package ram_ff_pkg:
  - bound constants DW_MAX=8192, AW_MAX=12, PORT_MAX=8
  - typedef for the port-index type
  - function for lowest-index priority select
- Sub-module ram_ff_wr_arb: takes enables and addresses; produces per-port commit mask plus collision flag. Combinational, instanced once.

Test Plan:
1. Reset then read all 8 addresses (RD_REG=1, default widths) -> data_r=0x00 on every port; rd_valid=1 one cycle after enable; collision_cnt=0.
2. Write port0 addr2=0xA5 and port1 addr5=0x3C in the same cycle, then read addr2/addr5 on ports 0/1 -> 0xA5 / 0x3C; wr_collision stays 0.
3. Port0 and port1 both write addr3 (0x11 vs 0x22) -> mem[3]=0x11; wr_collision pulses for one cycle; collision_cnt=1. Repeat 300 times with CNT_W=8 -> collision_cnt saturates at 255.
4. Write addr4=0x77 while reading addr4 in the same cycle (RD_REG=1) -> data_r=old value 0x00 without RAM_FF_BYPASS_EN; 0x77 with it.
5. Assert rst_n=0 in the same cycle as a write addr1=0xFF -> mem[1]=0x00, all outputs 0 the next cycle.
6. RD_REG=0, NUM_WR=4, NUM_RD=3: random traffic for 2000 cycles against a reference model -> zero mismatches; disabled read ports show data_r=0 and rd_valid=0.
